// File: rtl/rlwe_dmem_pkg.sv
// ----------------------------------------------------------------------------
// rlwe_dmem_pkg
// Shared types and helpers for the RLWE DMEM responder.
//   - DMEM command / width / response encodings used on the req/ack/resp port
//   - type_vector: LANE x 32-bit load/store data
//   - idx_w / addr_idx_w: index-width helpers (never returns 0)
//   - BEAT_W: beat counter width for the default lane count
//   - dmem_state_e: responder FSM states
// ----------------------------------------------------------------------------
package rlwe_dmem_pkg;

  localparam int RLWE_LANE  = 16;
  localparam int RLWE_DEPTH = 4096;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD = 2'b00,
    SCR1_MEM_CMD_WR = 2'b01
  } type_scr1_mem_cmd_e;

  typedef enum logic [2:0] {
    SCR1_MEM_WIDTH_BYTE   = 3'd0,
    SCR1_MEM_WIDTH_HWORD  = 3'd1,
    SCR1_MEM_WIDTH_WORD   = 3'd2,
    SCR1_MEM_WIDTH_VECTOR = 3'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef logic [RLWE_LANE-1:0][31:0] type_vector;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEC_RD = 2'd1,
    ST_VEC_WR = 2'd2,
    ST_RESP   = 2'd3
  } dmem_state_e;

  // Width of an index into n entries; at least 1 so it can size a vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Word-index width of a DEPTH-word SRAM.
  function automatic int addr_idx_w(input int depth);
    return idx_w(depth);
  endfunction

  localparam int BEAT_W     = idx_w(RLWE_LANE);
  localparam int ADDR_IDX_W = addr_idx_w(RLWE_DEPTH);

endpackage

// File: rtl/rlwe_dmem_word_ram.sv
// ----------------------------------------------------------------------------
// rlwe_dmem_word_ram
// Single-port DEPTH x 32 SRAM with per-byte write enables and a registered
// read port. Contents are not reset. Kept as its own module so it can be
// replaced by a foundry macro with the same port behaviour.
// Ports:
//   clk    clock
//   en     access enable (read when !we, write when we)
//   we     write enable
//   be     byte enables, bit b covers wdata[8b+7:8b]
//   addr   word index
//   wdata  write data
//   rdata  read data, valid the cycle after a read access; holds otherwise
// ----------------------------------------------------------------------------
module rlwe_dmem_word_ram
  import rlwe_dmem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = addr_idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rlwe_dmem_vec_responder.sv
// ----------------------------------------------------------------------------
// rlwe_dmem_vec_responder
// Slave end of the RLWE DMEM interface. Serves byte, halfword, word and
// LANE-word vector loads/stores from a local word-wide SRAM. Vector accesses
// take one SRAM word per cycle, so the block is busy (ack low) for LANE
// cycles after accepting a vector request, then answers in a one-cycle RESP.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   dmem_req       request valid
//   dmem_cmd       RD / WR
//   dmem_width     BYTE / HWORD / WORD / VECTOR
//   dmem_addr      byte address
//   dmem_wdata     store data (scalar stores use lane 0)
//   dmem_req_ack   request accepted this cycle (high whenever idle)
//   dmem_rdata     load data, holds until the next read response
//   dmem_resp      NOTRDY / RDY_OK / RDY_ER, non-NOTRDY only in RESP
// LANE >= 2 and DEPTH >= LANE are assumed.
// ----------------------------------------------------------------------------
module rlwe_dmem_vec_responder
  import rlwe_dmem_pkg::*;
#(
  parameter int                 LANE      = RLWE_LANE,
  parameter int                 AWIDTH    = 32,
  parameter int                 DEPTH     = RLWE_DEPTH,
  parameter logic [AWIDTH-1:0]  BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dmem_req,
  input  type_scr1_mem_cmd_e         dmem_cmd,
  input  type_scr1_mem_width_e       dmem_width,
  input  logic [AWIDTH-1:0]          dmem_addr,
  input  logic [LANE-1:0][31:0]      dmem_wdata,
  output logic                       dmem_req_ack,
  output logic [LANE-1:0][31:0]      dmem_rdata,
  output type_scr1_mem_resp_e        dmem_resp
);

  localparam int BW = idx_w(LANE);
  localparam int IW = addr_idx_w(DEPTH);

  dmem_state_e               state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  type_scr1_mem_resp_e       resp_q, resp_d;
  logic [LANE-1:0][31:0]     rdata_q, rdata_d;
  logic [LANE-1:0][31:0]     wdata_q, wdata_d;
  logic [IW-1:0]             idx_q, idx_d;
  type_scr1_mem_width_e      width_q, width_d;
  logic [1:0]                boff_q, boff_d;
  logic                      rd_fwd_q, rd_fwd_d;   // RESP of a successful read
  logic                      rd_vec_q, rd_vec_d;   // that read was a vector

  logic                      ram_en, ram_we;
  logic [3:0]                ram_be;
  logic [IW-1:0]             ram_addr;
  logic [31:0]               ram_wdata, ram_rdata;

  // --------------------------------------------------------------------------
  // Request decode and error check on the live inputs (used only at accept)
  // --------------------------------------------------------------------------
  logic                      accept;
  logic [AWIDTH-1:0]         off, widx;
  logic [AWIDTH:0]           last_idx;
  logic                      out_first, out_last, cmd_err, width_err, req_err;
  logic                      is_vec;

  assign accept   = dmem_req && (state_q == ST_IDLE);
  assign off      = dmem_addr - BASE_ADDR;
  assign widx     = off >> 2;
  // One extra bit so the last-word sum cannot wrap past the top of the space.
  assign last_idx = {1'b0, widx} + (AWIDTH+1)'(LANE-1);

  assign out_first = (dmem_addr < BASE_ADDR) || (widx >= AWIDTH'(DEPTH));
  assign out_last  = last_idx >= (AWIDTH+1)'(DEPTH);
  assign cmd_err   = (dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR);

  always_comb begin
    width_err = 1'b0;
    is_vec    = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:   width_err = 1'b0;
      SCR1_MEM_WIDTH_HWORD:  width_err = dmem_addr[0];
      SCR1_MEM_WIDTH_WORD:   width_err = |dmem_addr[1:0];
      SCR1_MEM_WIDTH_VECTOR: begin
        is_vec    = 1'b1;
        width_err = (|dmem_addr[BW+1:0]) || out_last;
      end
      default:               width_err = 1'b1;
    endcase
  end

  assign req_err = out_first || cmd_err || width_err;

  // --------------------------------------------------------------------------
  // Read data output. The SRAM has one cycle of read latency, so the word
  // that completes a read (lane 0 of a scalar, lane LANE-1 of a vector) is
  // still in the SRAM output register during RESP; it is forwarded here and
  // committed into rdata_q at the end of RESP.
  // --------------------------------------------------------------------------
  logic [BW-1:0] fwd_lane;
  logic [31:0]   fwd_word;
  logic [7:0]    rd_byte;

  always_comb begin
    case (boff_q)
      2'd0:    rd_byte = ram_rdata[7:0];
      2'd1:    rd_byte = ram_rdata[15:8];
      2'd2:    rd_byte = ram_rdata[23:16];
      default: rd_byte = ram_rdata[31:24];
    endcase
  end

  always_comb begin
    fwd_lane = rd_vec_q ? BW'(LANE-1) : '0;
    if (rd_vec_q) begin
      fwd_word = ram_rdata;
    end else begin
      case (width_q)
        SCR1_MEM_WIDTH_BYTE:  fwd_word = {24'b0, rd_byte};
        SCR1_MEM_WIDTH_HWORD: fwd_word = {16'b0, boff_q[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
        default:              fwd_word = ram_rdata;
      endcase
    end
  end

  always_comb begin
    dmem_rdata = rdata_q;
    if (rd_fwd_q) begin
      dmem_rdata[fwd_lane] = fwd_word;
    end
  end

  assign dmem_req_ack = (state_q == ST_IDLE);
  assign dmem_resp    = resp_q;

  // --------------------------------------------------------------------------
  // Next-state logic and SRAM control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    resp_d    = SCR1_MEM_RESP_NOTRDY;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    width_d   = width_q;
    boff_d    = boff_q;
    rd_fwd_d  = 1'b0;
    rd_vec_d  = rd_vec_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = idx_q + IW'(beat_q);
    ram_wdata = wdata_q[beat_q];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = widx[IW-1:0];
          width_d = dmem_width;
          boff_d  = dmem_addr[1:0];
          wdata_d = dmem_wdata;
          if (req_err) begin
            state_d = ST_RESP;
            resp_d  = SCR1_MEM_RESP_RDY_ER;
          end else begin
            // Beat 0 (or the only access of a scalar) is issued right here.
            ram_en   = 1'b1;
            ram_addr = widx[IW-1:0];
            ram_we   = (dmem_cmd == SCR1_MEM_CMD_WR);
            if (is_vec) begin
              beat_d    = BW'(1);
              rd_vec_d  = 1'b1;
              ram_be    = 4'b1111;
              ram_wdata = dmem_wdata[0];
              state_d   = ram_we ? ST_VEC_WR : ST_VEC_RD;
            end else begin
              state_d  = ST_RESP;
              resp_d   = SCR1_MEM_RESP_RDY_OK;
              rd_vec_d = 1'b0;
              if (!ram_we) begin
                rd_fwd_d = 1'b1;
                rdata_d  = '0;   // lanes 1..LANE-1 of a scalar load read as 0
              end
              case (dmem_width)
                SCR1_MEM_WIDTH_BYTE: begin
                  ram_be    = 4'b0001 << dmem_addr[1:0];
                  ram_wdata = {4{dmem_wdata[0][7:0]}};
                end
                SCR1_MEM_WIDTH_HWORD: begin
                  ram_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                  ram_wdata = {2{dmem_wdata[0][15:0]}};
                end
                default: begin
                  ram_be    = 4'b1111;
                  ram_wdata = dmem_wdata[0];
                end
              endcase
            end
          end
        end
      end

      ST_VEC_RD: begin
        ram_en = 1'b1;
        // SRAM output now holds the word requested on the previous beat.
        rdata_d[beat_q - BW'(1)] = ram_rdata;
        if (beat_q == BW'(LANE-1)) begin
          beat_d   = '0;
          state_d  = ST_RESP;
          resp_d   = SCR1_MEM_RESP_RDY_OK;
          rd_fwd_d = 1'b1;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end

      ST_VEC_WR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        ram_be = 4'b1111;
        if (beat_q == BW'(LANE-1)) begin
          beat_d  = '0;
          state_d = ST_RESP;
          resp_d  = SCR1_MEM_RESP_RDY_OK;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end

      default: begin  // ST_RESP
        state_d = ST_IDLE;
        rdata_d = dmem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      resp_q   <= SCR1_MEM_RESP_NOTRDY;
      rdata_q  <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      width_q  <= SCR1_MEM_WIDTH_WORD;
      boff_q   <= '0;
      rd_fwd_q <= 1'b0;
      rd_vec_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      width_q  <= width_d;
      boff_q   <= boff_d;
      rd_fwd_q <= rd_fwd_d;
      rd_vec_q <= rd_vec_d;
    end
  end

  rlwe_dmem_word_ram #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_rlwe_dmem_vec_responder.sv
// ----------------------------------------------------------------------------
// Directed bench for rlwe_dmem_vec_responder (LANE=16, DEPTH=4096, base 0).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge or shortly after it, away from the rising (active) edge.
// ----------------------------------------------------------------------------
module tb_rlwe_dmem_vec_responder;
  import rlwe_dmem_pkg::*;

  localparam int LANE   = 16;
  localparam int AWIDTH = 32;
  localparam int DEPTH  = 4096;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   dmem_req;
  type_scr1_mem_cmd_e     dmem_cmd;
  type_scr1_mem_width_e   dmem_width;
  logic [AWIDTH-1:0]      dmem_addr;
  logic [LANE-1:0][31:0]  dmem_wdata;
  logic                   dmem_req_ack;
  logic [LANE-1:0][31:0]  dmem_rdata;
  type_scr1_mem_resp_e    dmem_resp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rlwe_dmem_vec_responder #(
    .LANE      (LANE),
    .AWIDTH    (AWIDTH),
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: waits for ack, releases the inputs (scrambled) the cycle
  // after accept, then counts cycles until a non-NOTRDY response.
  task automatic xact(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                      input logic [31:0] addr, input logic [LANE-1:0][31:0] wd,
                      output type_scr1_mem_resp_e resp, output int lat,
                      output logic [LANE-1:0][31:0] rd);
    int waited;
    @(negedge clk);
    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = w;
    dmem_addr  = addr;
    dmem_wdata = wd;
    waited     = 0;
    #1;
    while (!dmem_req_ack && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!dmem_req_ack) begin
      chk("accept_timeout", 32'(dmem_req_ack), 32'd1);
      dmem_req = 1'b0;
      resp = SCR1_MEM_RESP_NOTRDY;
      lat  = -1;
      rd   = '0;
      return;
    end
    @(negedge clk);
    dmem_req   = 1'b0;
    dmem_cmd   = SCR1_MEM_CMD_WR;
    dmem_width = SCR1_MEM_WIDTH_BYTE;
    dmem_addr  = 32'hFFFF_FFF0;
    dmem_wdata = {LANE{32'h5A5A_5A5A}};
    lat = 1;
    while (dmem_resp == SCR1_MEM_RESP_NOTRDY && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    resp = dmem_resp;
    rd   = dmem_rdata;
    $display("xact cmd=%0d width=%0d addr=0x%08h resp=%0d lat=%0d lane0=0x%08h",
             cmd, w, addr, resp, lat, rd[0]);
  endtask

  initial begin
    type_scr1_mem_resp_e   r;
    int                    l;
    int                    ack_hi;
    logic [LANE-1:0][31:0] wv;
    logic [LANE-1:0][31:0] rv;

    dmem_req   = 1'b0;
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr  = '0;
    dmem_wdata = '0;
    wv         = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack",    32'(dmem_req_ack), 32'd1);
    chk("rst_resp",   32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst_rdata0", dmem_rdata[0], 32'h0);
    chk("rst_rdata15", dmem_rdata[15], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scalar write / byte read
    wv[0] = 32'hDEAD_BEEF;
    xact(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, wv, r, l, rv);
    chk("wr_word_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("wr_word_lat", 32'(l), 32'd1);
    chk("wr_word_rdata_held", rv[0], 32'h0);

    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h13, '0, r, l, rv);
    chk("rd_b13_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("rd_b13_lat", 32'(l), 32'd1);
    chk("rd_b13_data", rv[0], 32'h0000_00DE);
    for (int i = 1; i < LANE; i++) chk($sformatf("rd_b13_lane%0d", i), rv[i], 32'h0);

    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h10, '0, r, l, rv);
    chk("rd_b10_data", rv[0], 32'h0000_00EF);

    // Sub-word stores merge into the existing word
    wv[0] = 32'h0000_0055;
    xact(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h11, wv, r, l, rv);
    chk("wr_b11_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    wv[0] = 32'h0000_1234;
    xact(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h12, wv, r, l, rv);
    chk("wr_h12_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, '0, r, l, rv);
    chk("rd_h12_data", rv[0], 32'h0000_1234);
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h10, '0, r, l, rv);
    chk("rd_h10_data", rv[0], 32'h0000_55EF);
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0, r, l, rv);
    chk("rd_w10_data", rv[0], 32'h1234_55EF);

    // Misaligned halfword: error, rdata untouched
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h21, '0, r, l, rv);
    chk("rd_h21_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("rd_h21_lat", 32'(l), 32'd1);
    chk("rd_h21_rdata_held", rv[0], 32'h1234_55EF);

    // Vector write then read at 0x40
    for (int i = 0; i < LANE; i++) wv[i] = 32'h1000 + 32'(i);
    xact(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h40, wv, r, l, rv);
    chk("wr_v40_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("wr_v40_lat", 32'(l), 32'd16);
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h40, '0, r, l, rv);
    chk("rd_v40_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("rd_v40_lat", 32'(l), 32'd16);
    for (int i = 0; i < LANE; i++) chk($sformatf("rd_v40_lane%0d", i), rv[i], 32'h1000 + 32'(i));
    @(negedge clk);
    chk("rd_v40_resp_1cyc", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rd_v40_hold15", dmem_rdata[15], 32'h0000_100F);
    chk("rd_v40_hold0", dmem_rdata[0], 32'h0000_1000);

    // Misaligned vector
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h44, '0, r, l, rv);
    chk("rd_v44_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("rd_v44_lat", 32'(l), 32'd1);

    // Range boundaries
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'(DEPTH*4), '0, r, l, rv);
    chk("rd_oor_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
    for (int i = 0; i < LANE; i++) wv[i] = 32'hC000 + 32'(i);
    xact(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'((DEPTH-LANE)*4), wv, r, l, rv);
    chk("wr_vtop_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'((DEPTH-LANE)*4), '0, r, l, rv);
    chk("rd_vtop_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("rd_vtop_lane15", rv[15], 32'h0000_C00F);
    chk("rd_vtop_lane3", rv[3], 32'h0000_C003);

    // Unknown encodings
    xact(SCR1_MEM_CMD_RD, type_scr1_mem_width_e'(3'd5), 32'h10, '0, r, l, rv);
    chk("bad_width_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
    xact(type_scr1_mem_cmd_e'(2'd3), SCR1_MEM_WIDTH_WORD, 32'h10, '0, r, l, rv);
    chk("bad_cmd_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));

    // Request held high across a vector read
    @(negedge clk);
    dmem_req   = 1'b1;
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_VECTOR;
    dmem_addr  = 32'h40;
    #1;
    chk("hold_ack_T", 32'(dmem_req_ack), 32'd1);
    ack_hi = 0;
    r = SCR1_MEM_RESP_NOTRDY;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (dmem_req_ack) ack_hi++;
      if (k == 16) r = dmem_resp;
    end
    chk("hold_ack_busy_cnt", 32'(ack_hi), 32'd0);
    chk("hold_resp_T16", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    @(negedge clk);
    #1;
    chk("hold_ack_T17", 32'(dmem_req_ack), 32'd1);
    @(negedge clk);
    dmem_req = 1'b0;
    l = 1;
    while (dmem_resp == SCR1_MEM_RESP_NOTRDY && l < 40) begin
      @(negedge clk);
      l++;
    end
    chk("hold_second_lat", 32'(l), 32'd16);
    chk("hold_second_lane7", dmem_rdata[7], 32'h0000_1007);
    $display("xact held vector read second resp lat=%0d", l);

    // Reset in the middle of a vector write to 0x80
    for (int i = 0; i < LANE; i++) wv[i] = 32'hA000 + 32'(i);
    xact(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h80, wv, r, l, rv);
    chk("wr_v80_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    for (int i = 0; i < LANE; i++) wv[i] = 32'hB000 + 32'(i);
    @(negedge clk);
    dmem_req   = 1'b1;
    dmem_cmd   = SCR1_MEM_CMD_WR;
    dmem_width = SCR1_MEM_WIDTH_VECTOR;
    dmem_addr  = 32'h80;
    dmem_wdata = wv;
    #1;
    chk("rstmid_ack_T", 32'(dmem_req_ack), 32'd1);
    @(negedge clk);
    dmem_req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rstmid_idle_ack", 32'(dmem_req_ack), 32'd1);
    chk("rstmid_rdata15", dmem_rdata[15], 32'h0);
    $display("xact vector write 0x80 interrupted by reset at beat 5");
    @(negedge clk);
    rst_n = 1'b1;
    xact(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h80, '0, r, l, rv);
    chk("rd_v80_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    for (int i = 0; i < LANE; i++)
      chk($sformatf("rd_v80_lane%0d", i), rv[i], (i < 5) ? 32'hB000 + 32'(i) : 32'hA000 + 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
